irb_dw_engine: RTL and testbench

Depthwise 3x3 convolution stage of the inverted-residual-block datapath. It sits between the expansion stage, which fills the FMINT tile RAM (Tix_T x Tiy_T x Npar), and the projection stage. It reads one FMINT tile and the matching DW kernels from KDW RAM, computes one output pixel at a time with a single serial MAC, and streams results to the projection stage over a valid/ready handshake.

---
 rtl/irb_dw_engine.sv | 225 ++++++++++++++++++++++
 tb/tb_irb_dw_engine.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/irb_dw_engine.sv
// ---------------------------------------------------------------------------
// irb_dw_engine
//   Depthwise 3x3 convolution stage of the inverted-residual-block datapath.
//   Reads one FMINT tile plus the matching depthwise kernels, computes one
//   output pixel at a time with a single serial MAC and hands each result to
//   the projection stage over a valid/ready handshake.
//
//   Ports:
//     clk, rst_n          clock (rising edge), asynchronous active-low reset
//     start, n_ch         launch pulse (IDLE only) and channel count
//     busy, done          status: processing / one-cycle completion pulse
//     fmint_rd_en/addr    FMINT tile RAM read port (rdata one cycle later)
//     fmint_rdata
//     kdw_rd_en/addr      KDW kernel RAM read port (rdata one cycle later)
//     kdw_rdata
//     out_valid/ready     result handshake towards the projection stage
//     out_data/addr
//
//   Build option: define DW_RELU_EN to clamp negative results to zero after
//   saturation. Without it the saturated signed result is passed through.
// ---------------------------------------------------------------------------
module irb_dw_engine #(
    parameter int NKX   = 3,
    parameter int NKY   = 3,
    parameter int TOX   = 7,
    parameter int TOY   = 7,
    parameter int NPAR  = 32,
    parameter int PX_W  = 16,
    parameter int WG_W  = 16,
    parameter int FRAC  = 8,
    parameter int ACC_W = PX_W + WG_W + 4
) (
    input  logic                                                  clk,
    input  logic                                                  rst_n,
    input  logic                                                  start,
    input  logic [$clog2(NPAR+1)-1:0]                             n_ch,
    output logic                                                  busy,
    output logic                                                  done,
    output logic                                                  fmint_rd_en,
    output logic [$clog2((TOX+NKX-1)*(TOY+NKY-1)*NPAR)-1:0]       fmint_addr,
    input  logic signed [PX_W-1:0]                                fmint_rdata,
    output logic                                                  kdw_rd_en,
    output logic [$clog2(NKX*NKY*NPAR)-1:0]                       kdw_addr,
    input  logic signed [WG_W-1:0]                                kdw_rdata,
    output logic                                                  out_valid,
    input  logic                                                  out_ready,
    output logic signed [PX_W-1:0]                                out_data,
    output logic [$clog2(TOX*TOY*NPAR)-1:0]                       out_addr
);

    localparam int TIX  = TOX + NKX - 1;
    localparam int TIY  = TOY + NKY - 1;
    localparam int CH_W = $clog2(NPAR + 1);
    localparam int OX_W = $clog2(TOX + 1);
    localparam int OY_W = $clog2(TOY + 1);
    localparam int KX_W = $clog2(NKX + 1);
    localparam int KY_W = $clog2(NKY + 1);
    localparam int FA_W = $clog2(TIX * TIY * NPAR);
    localparam int KA_W = $clog2(NKX * NKY * NPAR);
    localparam int OA_W = $clog2(TOX * TOY * NPAR);
    localparam int PR_W = PX_W + WG_W;

    localparam logic [CH_W-1:0] NPAR_C  = CH_W'(NPAR);
    localparam logic [OX_W-1:0] OX_LAST = OX_W'(TOX - 1);
    localparam logic [OY_W-1:0] OY_LAST = OY_W'(TOY - 1);
    localparam logic [KX_W-1:0] KX_LAST = KX_W'(NKX - 1);
    localparam logic [KY_W-1:0] KY_LAST = KY_W'(NKY - 1);

    localparam logic signed [ACC_W-1:0] PX_MAX_A = {{(ACC_W-PX_W+1){1'b0}}, {(PX_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] PX_MIN_A = ~PX_MAX_A;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_LAST  = 3'd2;
    localparam logic [2:0] S_OUT   = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    // Arithmetic shift (truncating) followed by saturation to the pixel range.
    function automatic logic signed [PX_W-1:0] sat_px(input logic signed [ACC_W-1:0] v);
        logic signed [ACC_W-1:0] sh;
        sh = v >>> FRAC;
        if (sh > PX_MAX_A)      sat_px = PX_MAX_A[PX_W-1:0];
        else if (sh < PX_MIN_A) sat_px = PX_MIN_A[PX_W-1:0];
        else                    sat_px = sh[PX_W-1:0];
    endfunction

    function automatic logic signed [PX_W-1:0] post_act(input logic signed [PX_W-1:0] v);
`ifdef DW_RELU_EN
        post_act = v[PX_W-1] ? '0 : v;
`else
        post_act = v;
`endif
    endfunction

    logic [2:0]      state_q, state_d;
    logic [CH_W-1:0] nch_q, nch_d;
    logic [CH_W-1:0] ch_q, ch_d;
    logic [OY_W-1:0] oy_q, oy_d;
    logic [OX_W-1:0] ox_q, ox_d;
    logic [KY_W-1:0] ky_q, ky_d;
    logic [KX_W-1:0] kx_q, kx_d;
    logic            rd_vld_q, rd_first_q;
    logic signed [ACC_W-1:0] acc_q;
    logic signed [PX_W-1:0]  out_data_q;
    logic [OA_W-1:0]         out_addr_q;

    logic signed [PR_W-1:0]  prod;
    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] acc_sum;
    int                      fa_int, ka_int, oa_int;

    assign busy        = (state_q == S_ISSUE) || (state_q == S_LAST) || (state_q == S_OUT);
    assign done        = (state_q == S_DONE);
    assign out_valid   = (state_q == S_OUT);
    assign fmint_rd_en = (state_q == S_ISSUE);
    assign kdw_rd_en   = (state_q == S_ISSUE);
    assign out_data    = out_data_q;
    assign out_addr    = out_addr_q;

    // Tap and output addresses; read addresses idle at zero when no read is issued.
    always_comb begin
        fa_int = int'(ch_q) * (TIX * TIY) + (int'(oy_q) + int'(ky_q)) * TIX + int'(ox_q) + int'(kx_q);
        ka_int = int'(ch_q) * (NKX * NKY) + int'(ky_q) * NKX + int'(kx_q);
        oa_int = int'(ch_q) * (TOX * TOY) + int'(oy_q) * TOX + int'(ox_q);
        fmint_addr = fmint_rd_en ? FA_W'(fa_int) : '0;
        kdw_addr   = kdw_rd_en   ? KA_W'(ka_int) : '0;
    end

    // MAC datapath: data returned for a tap is accumulated one cycle after issue.
    assign prod     = fmint_rdata * kdw_rdata;
    assign prod_ext = {{(ACC_W-PR_W){prod[PR_W-1]}}, prod};
    assign acc_sum  = rd_first_q ? prod_ext : (acc_q + prod_ext);

    always_comb begin
        state_d = state_q;
        nch_d   = nch_q;
        ch_d    = ch_q;
        oy_d    = oy_q;
        ox_d    = ox_q;
        ky_d    = ky_q;
        kx_d    = kx_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    nch_d   = (n_ch > NPAR_C) ? NPAR_C : n_ch;
                    ch_d    = '0;
                    oy_d    = '0;
                    ox_d    = '0;
                    ky_d    = '0;
                    kx_d    = '0;
                    state_d = (n_ch == '0) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (kx_q == KX_LAST) begin
                    kx_d = '0;
                    if (ky_q == KY_LAST) begin
                        ky_d    = '0;
                        state_d = S_LAST;
                    end else begin
                        ky_d = ky_q + 1'b1;
                    end
                end else begin
                    kx_d = kx_q + 1'b1;
                end
            end
            S_LAST: state_d = S_OUT;
            S_OUT: begin
                if (out_ready) begin
                    state_d = S_ISSUE;
                    if (ox_q == OX_LAST) begin
                        ox_d = '0;
                        if (oy_q == OY_LAST) begin
                            oy_d = '0;
                            if (ch_q == nch_q - 1'b1) state_d = S_DONE;
                            else                      ch_d    = ch_q + 1'b1;
                        end else begin
                            oy_d = oy_q + 1'b1;
                        end
                    end else begin
                        ox_d = ox_q + 1'b1;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            nch_q      <= '0;
            ch_q       <= '0;
            oy_q       <= '0;
            ox_q       <= '0;
            ky_q       <= '0;
            kx_q       <= '0;
            rd_vld_q   <= 1'b0;
            rd_first_q <= 1'b0;
            out_data_q <= '0;
            out_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            nch_q      <= nch_d;
            ch_q       <= ch_d;
            oy_q       <= oy_d;
            ox_q       <= ox_d;
            ky_q       <= ky_d;
            kx_q       <= kx_d;
            rd_vld_q   <= fmint_rd_en;
            rd_first_q <= fmint_rd_en && (kx_q == '0) && (ky_q == '0);
            // LAST folds in the final tap and registers the finished pixel.
            if (state_q == S_LAST) begin
                out_data_q <= post_act(sat_px(acc_sum));
                out_addr_q <= OA_W'(oa_int);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rd_vld_q) acc_q <= acc_sum;
    end

endmodule

// File: tb/tb_irb_dw_engine.sv
`timescale 1ns/1ps
module tb_irb_dw_engine;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic [5:0]         n_ch = '0;
    logic               busy, done;
    logic               fmint_rd_en, kdw_rd_en;
    logic [11:0]        fmint_addr;
    logic [8:0]         kdw_addr;
    logic signed [15:0] fmint_rdata = '0;
    logic signed [15:0] kdw_rdata = '0;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic [15:0]        out_data;
    logic [10:0]        out_addr;

    int total = 0;
    int bad = 0;

    logic signed [15:0] fm_mem [0:2591];
    logic signed [15:0] kw_mem [0:287];

    int          exp_addr_q [$];
    logic [15:0] exp_data_q [$];

    irb_dw_engine dut (
        .clk(clk), .rst_n(rst_n), .start(start), .n_ch(n_ch),
        .busy(busy), .done(done),
        .fmint_rd_en(fmint_rd_en), .fmint_addr(fmint_addr), .fmint_rdata(fmint_rdata),
        .kdw_rd_en(kdw_rd_en), .kdw_addr(kdw_addr), .kdw_rdata(kdw_rdata),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_addr(out_addr)
    );

    always #5 clk = ~clk;

    // Synchronous RAM models, one cycle read latency.
    always @(posedge clk) begin
        if (fmint_rd_en) fmint_rdata <= fm_mem[fmint_addr];
        if (kdw_rd_en)   kdw_rdata   <= kw_mem[kdw_addr];
    end

    function automatic logic [15:0] model_px(input int c, input int oy, input int ox);
        longint acc;
        acc = 0;
        for (int ky = 0; ky < 3; ky++)
            for (int kx = 0; kx < 3; kx++)
                acc += longint'(fm_mem[c*81 + (oy+ky)*9 + ox + kx]) * longint'(kw_mem[c*9 + ky*3 + kx]);
        acc = acc >>> 8;
        if (acc > 32767)       acc = 32767;
        else if (acc < -32768) acc = -32768;
`ifdef DW_RELU_EN
        if (acc < 0) acc = 0;
`endif
        return acc[15:0];
    endfunction

    task automatic push_expected(input int nch);
        for (int c = 0; c < nch; c++)
            for (int oy = 0; oy < 7; oy++)
                for (int ox = 0; ox < 7; ox++) begin
                    exp_addr_q.push_back(c*49 + oy*7 + ox);
                    exp_data_q.push_back(model_px(c, oy, ox));
                end
    endtask

    task automatic fill_fm(input int v);
        for (int i = 0; i < 2592; i++) fm_mem[i] = 16'(v);
    endtask

    task automatic fill_kw(input int v);
        for (int i = 0; i < 288; i++) kw_mem[i] = 16'(v);
    endtask

    // Launches one tile and consumes the stream against the scoreboard.
    task automatic run_tile(input int nch, input int stall_pix, input int restart_cyc, input int abort_pix,
                            output int hs, output int first_vld, output int done_cyc,
                            output int done_cnt, output int reads, output int last_addr);
        int          cyc, stall_left, ea;
        bit          stall_done, finished;
        logic [15:0] hold_data, ed;
        logic [10:0] hold_addr;
        hs = 0; first_vld = -1; done_cyc = -1; done_cnt = 0; reads = 0; last_addr = -1;
        stall_left = 0; stall_done = 0; finished = 0;
        @(negedge clk);
        n_ch = 6'(nch); start = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (!finished && cyc < 20000) begin
            start = (cyc == restart_cyc);
            if (cyc == restart_cyc) n_ch = 6'd3;
            if (fmint_rd_en) reads++;
            if (fmint_rd_en || kdw_rd_en) begin
                total++;
                if (kdw_rd_en !== fmint_rd_en) begin
                    bad++;
                    $display("FAIL rd_en_pair cyc=%0d fmint=%b kdw=%b required equal", cyc, fmint_rd_en, kdw_rd_en);
                end
            end
            if (out_valid && first_vld < 0) first_vld = cyc;
            if (abort_pix >= 0 && hs == abort_pix && fmint_rd_en) begin
                rst_n = 1'b0;
                finished = 1;
            end else begin
                if (out_valid && hs == stall_pix && !stall_done) begin
                    stall_done = 1; stall_left = 5;
                    hold_data = out_data; hold_addr = out_addr;
                end
                if (stall_left > 0) begin
                    out_ready = 1'b0;
                    stall_left--;
                    total++;
                    if (out_data !== hold_data || out_addr !== hold_addr || fmint_rd_en !== 1'b0 || out_valid !== 1'b1) begin
                        bad++;
                        $display("FAIL stall_hold cyc=%0d data=%h addr=%0d rd=%b vld=%b required data=%h addr=%0d rd=0 vld=1",
                                 cyc, out_data, out_addr, fmint_rd_en, out_valid, hold_data, hold_addr);
                    end
                end else begin
                    out_ready = 1'b1;
                end
                if (out_valid && out_ready) begin
                    total++;
                    if (exp_addr_q.size() == 0) begin
                        bad++;
                        $display("FAIL extra_output addr=%0d data=%h required none", out_addr, out_data);
                    end else begin
                        ea = exp_addr_q.pop_front();
                        ed = exp_data_q.pop_front();
                        if (out_addr !== 11'(ea) || out_data !== ed || busy !== 1'b1) begin
                            bad++;
                            $display("FAIL pixel addr=%0d data=%h busy=%b required addr=%0d data=%h busy=1",
                                     out_addr, out_data, busy, ea, ed);
                        end
                    end
                    hs++;
                    last_addr = int'(out_addr);
                end
                if (done) begin
                    done_cnt++; done_cyc = cyc;
                    total++;
                    if (busy !== 1'b0) begin
                        bad++;
                        $display("FAIL busy_in_done busy=%b required 0", busy);
                    end
                    @(negedge clk); cyc++;
                    total++;
                    if (done !== 1'b0 || busy !== 1'b0 || fmint_rd_en !== 1'b0) begin
                        bad++;
                        $display("FAIL done_pulse done=%b busy=%b rd=%b required 0 0 0", done, busy, fmint_rd_en);
                    end
                    finished = 1;
                end
            end
            if (!finished) begin
                @(negedge clk); cyc++;
            end
        end
        start = 1'b0;
        out_ready = 1'b1;
        if (!finished) begin
            total++; bad++;
            $display("FAIL timeout cyc=%0d hs=%0d required done", cyc, hs);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || out_valid !== 1'b0) begin
            bad++; $display("FAIL reset_status busy=%b done=%b vld=%b required 0", busy, done, out_valid);
        end
        total++;
        if (fmint_rd_en !== 1'b0 || kdw_rd_en !== 1'b0) begin
            bad++; $display("FAIL reset_rd fmint=%b kdw=%b required 0", fmint_rd_en, kdw_rd_en);
        end
        total++;
        if (fmint_addr !== '0 || kdw_addr !== '0 || out_addr !== '0 || out_data !== '0) begin
            bad++; $display("FAIL reset_data fa=%0d ka=%0d oa=%0d od=%h required 0", fmint_addr, kdw_addr, out_addr, out_data);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || fmint_rd_en !== 1'b0) begin
            bad++; $display("FAIL idle_after_reset busy=%b vld=%b rd=%b required 0", busy, out_valid, fmint_rd_en);
        end
    endtask

    task automatic test_uniform();
        int hs, fv, dc, dn, rd, la;
        fill_fm(16'h0100); fill_kw(16'h0100);
        push_expected(1);
        run_tile(1, -1, -1, -1, hs, fv, dc, dn, rd, la);
        total++; if (hs !== 49) begin bad++; $display("FAIL uniform_count got=%0d required 49", hs); end
        total++; if (fv !== 11) begin bad++; $display("FAIL first_valid_latency got=%0d required 11", fv); end
        total++; if (dc !== 540) begin bad++; $display("FAIL uniform_done_cycle got=%0d required 540", dc); end
        total++; if (dn !== 1) begin bad++; $display("FAIL uniform_done_count got=%0d required 1", dn); end
        total++; if (rd !== 49*9) begin bad++; $display("FAIL uniform_reads got=%0d required %0d", rd, 49*9); end
    endtask

    task automatic test_window();
        int hs, fv, dc, dn, rd, la;
        fill_kw(0);
        for (int i = 0; i < 81; i++) fm_mem[i] = 16'(i);
        kw_mem[4] = 16'sh0100;
        push_expected(1);
        run_tile(1, -1, -1, -1, hs, fv, dc, dn, rd, la);
        total++; if (hs !== 49 || exp_addr_q.size() !== 0) begin
            bad++; $display("FAIL window_count got=%0d left=%0d required 49 0", hs, exp_addr_q.size());
        end
    endtask

    task automatic test_saturation();
        int hs, fv, dc, dn, rd, la;
        fill_fm(16'h7FFF); fill_kw(16'h7FFF);
        push_expected(1);
        run_tile(1, -1, -1, -1, hs, fv, dc, dn, rd, la);
        total++; if (hs !== 49) begin bad++; $display("FAIL sat_pos_count got=%0d required 49", hs); end
        fill_fm(16'h8000);
        push_expected(1);
        run_tile(1, -1, -1, -1, hs, fv, dc, dn, rd, la);
        total++; if (hs !== 49) begin bad++; $display("FAIL sat_neg_count got=%0d required 49", hs); end
    endtask

    task automatic test_backpressure();
        int hs, fv, dc, dn, rd, la;
        for (int i = 0; i < 81; i++) fm_mem[i] = 16'($urandom_range(0, 65535));
        for (int i = 0; i < 9; i++)  kw_mem[i] = 16'($urandom_range(0, 65535));
        push_expected(1);
        run_tile(1, 3, -1, -1, hs, fv, dc, dn, rd, la);
        total++; if (hs !== 49) begin bad++; $display("FAIL bp_count got=%0d required 49", hs); end
        total++; if (dc !== 545) begin bad++; $display("FAIL bp_done_cycle got=%0d required 545", dc); end
        total++; if (rd !== 49*9) begin bad++; $display("FAIL bp_reads got=%0d required %0d", rd, 49*9); end
    endtask

    task automatic test_full_tile();
        int hs, fv, dc, dn, rd, la;
        for (int i = 0; i < 2592; i++) fm_mem[i] = 16'((i*37) % 1000 - 500);
        fill_kw(0);
        for (int c = 0; c < 32; c++) kw_mem[c*9 + 4] = 16'(c << 8);
        push_expected(32);
        run_tile(32, -1, 500, -1, hs, fv, dc, dn, rd, la);
        total++; if (hs !== 1568) begin bad++; $display("FAIL full_count got=%0d required 1568", hs); end
        total++; if (la !== 1567) begin bad++; $display("FAIL full_last_addr got=%0d required 1567", la); end
        total++; if (dc !== 1568*11+1) begin bad++; $display("FAIL full_done_cycle got=%0d required %0d", dc, 1568*11+1); end
        run_tile(0, -1, -1, -1, hs, fv, dc, dn, rd, la);
        total++; if (dc !== 1) begin bad++; $display("FAIL zero_ch_done got=%0d required 1", dc); end
        total++; if (rd !== 0 || hs !== 0) begin bad++; $display("FAIL zero_ch_activity reads=%0d hs=%0d required 0 0", rd, hs); end
    endtask

    task automatic test_reset_midrun();
        int hs, fv, dc, dn, rd, la;
        for (int i = 0; i < 81; i++) fm_mem[i] = 16'($urandom_range(0, 2000) - 1000);
        for (int i = 0; i < 9; i++)  kw_mem[i] = 16'($urandom_range(0, 1000));
        push_expected(1);
        run_tile(1, -1, -1, 10, hs, fv, dc, dn, rd, la);
        #1;
        total++; if (hs !== 10) begin bad++; $display("FAIL abort_point hs=%0d required 10", hs); end
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || out_valid !== 1'b0 || fmint_rd_en !== 1'b0 || kdw_rd_en !== 1'b0 ||
            fmint_addr !== '0 || kdw_addr !== '0 || out_addr !== '0 || out_data !== '0) begin
            bad++;
            $display("FAIL abort_outputs busy=%b done=%b vld=%b rd=%b%b fa=%0d ka=%0d oa=%0d od=%h required all 0",
                     busy, done, out_valid, fmint_rd_en, kdw_rd_en, fmint_addr, kdw_addr, out_addr, out_data);
        end
        exp_addr_q.delete();
        exp_data_q.delete();
        repeat (2) @(negedge clk);
        total++;
        if (fmint_rd_en !== 1'b0 || done !== 1'b0) begin
            bad++; $display("FAIL abort_quiet rd=%b done=%b required 0 0", fmint_rd_en, done);
        end
        rst_n = 1'b1;
        push_expected(1);
        run_tile(1, -1, -1, -1, hs, fv, dc, dn, rd, la);
        total++; if (hs !== 49 || dc !== 540) begin bad++; $display("FAIL restart_run hs=%0d done=%0d required 49 540", hs, dc); end
    endtask

    initial begin
        test_reset();
        test_uniform();
        test_window();
        test_saturation();
        test_backpressure();
        test_full_tile();
        test_reset_midrun();
        total++;
        if (exp_addr_q.size() !== 0) begin
            bad++; $display("FAIL scoreboard_drained left=%0d required 0", exp_addr_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
